io_handshake_ctrl: RTL and testbench



---
 rtl/io_handshake_ctrl.sv | 106 ++++++++++
 tb/tb_io_handshake_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/io_handshake_ctrl.sv
// I/O stall-handshake responder: services in/out requests from the control unit
// using a debounced confirm button. Optional macro IO_SIGN_EXT_EN sign-extends switches.
module io_handshake_ctrl #(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_req,
  input  logic                out_req,
  input  logic [31:0]         dado_out,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                botao,
  output logic                sinal,
  output logic [31:0]         dado_in,
  output logic [31:0]         display,
  output logic                out_valid,
  output logic                aguardando
);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, ACK} state_t;

  state_t               state, state_nxt;
  logic                 kind_in, kind_in_nxt;
  logic [1:0]           btn_sync;
  logic                 btn_s;
  logic                 req, req_prev, start;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 lvl_match, cnt_done;
  logic                 capture, load_out;
  logic [31:0]          sw_ext;

  assign btn_s = btn_sync[1];
  assign req   = in_req | out_req;
  assign start = req & ~req_prev;

`ifdef IO_SIGN_EXT_EN
  assign sw_ext = 32'($signed(switches));
`else
  assign sw_ext = 32'(switches);
`endif

  // Press phase waits for a stable high level, release phase for a stable low.
  assign lvl_match = (state == WAIT_PRESS) ? btn_s : ~btn_s;
  assign cnt_done  = lvl_match && (cnt >= CNT_WIDTH'(DEBOUNCE_CYCLES - 1));

  assign sinal      = (state == ACK);
  assign aguardando = (state == WAIT_PRESS) || (state == WAIT_RELEASE);

  always_comb begin
    state_nxt   = state;
    kind_in_nxt = kind_in;
    cnt_nxt     = cnt;
    capture     = 1'b0;
    load_out    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) begin
          state_nxt   = WAIT_PRESS;
          kind_in_nxt = in_req;   // in wins when both rise together
          load_out    = ~in_req;
        end
      end
      WAIT_PRESS, WAIT_RELEASE: begin
        if (!lvl_match) begin
          cnt_nxt = '0;
        end else if (cnt_done) begin
          cnt_nxt   = '0;
          state_nxt = (state == WAIT_PRESS) ? WAIT_RELEASE : ACK;
          capture   = (state == WAIT_PRESS) && kind_in;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_sync  <= '0;
      req_prev  <= 1'b0;
      state     <= IDLE;
      kind_in   <= 1'b0;
      cnt       <= '0;
      dado_in   <= '0;
      display   <= '0;
      out_valid <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[0], botao};
      req_prev <= req;
      state    <= state_nxt;
      kind_in  <= kind_in_nxt;
      cnt      <= cnt_nxt;
      if (capture) dado_in <= sw_ext;
      if (load_out) begin
        display   <= dado_out;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_handshake_ctrl.sv
// Bench for io_handshake_ctrl: directed scenarios plus randomized transactions,
// compared every cycle against a window-based behavioural model.
module tb_io_handshake_ctrl;
  localparam int SW = 16;
  localparam int D  = 4;

  logic          clock = 1'b0, reset = 1'b1;
  logic          in_req = 1'b0, out_req = 1'b0, botao = 1'b0;
  logic [31:0]   dado_out = '0;
  logic [SW-1:0] switches = '0;
  logic          sinal, out_valid, aguardando;
  logic [31:0]   dado_in, display;

  io_handshake_ctrl #(.SW_WIDTH(SW), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(20)) dut (
    .clock(clock), .reset(reset), .in_req(in_req), .out_req(out_req),
    .dado_out(dado_out), .switches(switches), .botao(botao), .sinal(sinal),
    .dado_in(dado_in), .display(display), .out_valid(out_valid), .aguardando(aguardando)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_pass = 0, n_fail = 0, pulses = 0;

  // Model: phase 0 idle, 1 awaiting press, 2 awaiting release, 3 acknowledge.
  int          edge_n = 0, last_rst = -100, phase = 0, entry = 0;
  bit          kind_in = 0, m_req_prev = 0;
  bit          bh [8192];
  logic [31:0] m_dado_in = '0, m_display = '0;
  bit          m_valid = 0;
  logic [31:0] d4;
  logic [SW-1:0] sw3;

  // Synchronized button as seen by the control logic at edge e.
  function automatic bit btn_s_at(int e);
    if (e < 2 || e - 2 <= last_rst) return 1'b0;
    return bh[(e - 2) % 8192];
  endfunction

  function automatic logic [31:0] ext(logic [SW-1:0] s);
`ifdef IO_SIGN_EXT_EN
    if (s[SW-1]) return {16'hFFFF, s};
`endif
    return {16'h0000, s};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit lvl, ok;
    edge_n++;
    bh[edge_n % 8192] = botao;
    if (reset) begin
      last_rst = edge_n; phase = 0; m_req_prev = 0;
      m_dado_in = '0; m_display = '0; m_valid = 0;
      return;
    end
    case (phase)
      0: if ((in_req | out_req) && !m_req_prev) begin
           phase = 1; entry = edge_n; kind_in = in_req;
           if (!in_req) begin m_display = dado_out; m_valid = 1; end
         end
      1, 2: begin
        lvl = (phase == 1);
        ok  = 1;
        for (int k = 0; k < D; k++)
          if (edge_n - k <= entry || btn_s_at(edge_n - k) != lvl) ok = 0;
        if (ok) begin
          if (phase == 1 && kind_in) m_dado_in = ext(switches);
          phase = phase + 1; entry = edge_n;
        end
      end
      default: phase = 0;
    endcase
    m_req_prev = in_req | out_req;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    if (sinal === 1'b1) pulses++;
    chk("sinal", sinal, phase == 3);
    chk("aguardando", aguardando, phase == 1 || phase == 2);
    chk("dado_in", dado_in, m_dado_in);
    chk("display", display, m_display);
    chk("out_valid", out_valid, m_valid);
  endtask

  task automatic bot(logic lvl, int n);
    botao = lvl;
    repeat (n) tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_sinal", sinal, 0);
    chk("rst_dado_in", dado_in, 0);
    chk("rst_display", display, 0);
    chk("rst_aguardando", aguardando, 0);
    reset = 1'b0; tick();

    // Basic IN: capture on 6th pressed cycle, sinal on 6th released cycle.
    switches = 16'h00A5; in_req = 1; pulses = 0; tick();
    chk("t2_wait", aguardando, 1);
    bot(1, 5); chk("t2_pre_cap", dado_in, 0);
    bot(1, 1); chk("t2_cap", dado_in, 32'h000000A5);
    bot(1, 4);
    bot(0, 5); chk("t2_pre_ack", pulses, 0);
    bot(0, 1); chk("t2_sinal", sinal, 1);
    bot(0, 4); chk("t2_pulses", pulses, 1);
    in_req = 0; tick(); tick();

    // Bounce never accepted; only the stable run captures.
    sw3 = 16'(($urandom_range(1, 16'hFFFE) & 16'hFF00) | 16'h0011);
    switches = sw3; in_req = 1; pulses = 0; tick();
    bot(1, 2); bot(0, 1); bot(1, 3); bot(0, 1);
    chk("t3_no_cap", dado_in, 32'h000000A5);
    bot(1, 8); chk("t3_cap", dado_in, ext(sw3));
    bot(0, 8); chk("t3_pulses", pulses, 1);
    in_req = 0; tick(); tick();

    // OUT: display loads on the start edge, held request never retriggers.
    dado_out = 32'h00001234; out_req = 1; pulses = 0; tick();
    chk("t4_display", display, 32'h00001234);
    chk("t4_valid", out_valid, 1);
    bot(1, 8); bot(0, 8); chk("t4_pulses", pulses, 1);
    repeat (20) tick();
    chk("t4_hold_pulses", pulses, 1);
    chk("t4_hold_display", display, 32'h00001234);
    out_req = 0; tick();
    d4 = $urandom | 32'h1; dado_out = d4; out_req = 1; pulses = 0; tick();
    chk("t4_redisplay", display, d4);
    bot(1, 8); bot(0, 8); chk("t4_re_pulses", pulses, 1);
    out_req = 0; tick(); tick();

    // Simultaneous in/out: in wins, display untouched.
    switches = 16'h0003; dado_out = ~d4; in_req = 1; out_req = 1; tick();
    chk("t5_display_kept", display, d4);
    bot(1, 8); bot(0, 8);
    chk("t5_dado_in", dado_in, 32'h00000003);
    chk("t5_display", display, d4);
    in_req = 0; out_req = 0; tick(); tick();

    // Extension of the top switch bit.
    switches = 16'h8001; in_req = 1; tick();
    bot(1, 8);
`ifdef IO_SIGN_EXT_EN
    chk("t6_ext", dado_in, 32'hFFFF8001);
`else
    chk("t6_ext", dado_in, 32'h00008001);
`endif
    bot(0, 8); in_req = 0; tick(); tick();

    // Reset in the middle of a transaction.
    switches = 16'h5A5A; in_req = 1; pulses = 0; tick();
    bot(1, 3);
    reset = 1;
    repeat (3) begin
      in_req = 1'($urandom); out_req = 1'($urandom); botao = 1'($urandom);
      switches = 16'($urandom); dado_out = $urandom;
      tick();
      chk("t1_sinal", sinal, 0);
      chk("t1_dado_in", dado_in, 0);
      chk("t1_display", display, 0);
      chk("t1_valid", out_valid, 0);
      chk("t1_aguardando", aguardando, 0);
    end
    in_req = 0; out_req = 0; botao = 0; reset = 0;
    repeat (4) tick();
    chk("t1_no_pulse", pulses, 0);

    // Randomized transactions with bouncy button and changing switches.
    for (int t = 0; t < 40; t++) begin
      int budget, run_left;
      bit done;
      switches = 16'($urandom); dado_out = $urandom;
      case ($urandom_range(0, 2))
        0:       in_req = 1;
        1:       out_req = 1;
        default: begin in_req = 1; out_req = 1; end
      endcase
      tick();
      budget = 0; run_left = 0; done = 0;
      while (!done && budget < 300) begin
        if (run_left == 0) begin botao = ~botao; run_left = $urandom_range(1, 7); end
        run_left--;
        if ($urandom_range(0, 3) == 0) switches = 16'($urandom);
        tick(); budget++;
        if (phase == 3) done = 1;
      end
      chk("rand_done", done, 1);
      in_req = 0; out_req = 0; botao = 0;
      repeat (3) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
